// File: rtl/ap_perf_pkg.sv
// Shared definitions for the ap_ctrl handshake performance monitor.
//   - read-port register indices
//   - status word bit positions
//   - start-tracker state encoding
//   - saturating increment used by every event counter
package ap_perf_pkg;

    localparam logic [2:0] REG_TXN   = 3'd0;
    localparam logic [2:0] REG_LAST  = 3'd1;
    localparam logic [2:0] REG_MIN   = 3'd2;
    localparam logic [2:0] REG_MAX   = 3'd3;
    localparam logic [2:0] REG_II    = 3'd4;
    localparam logic [2:0] REG_STALL = 3'd5;
    localparam logic [2:0] REG_STAT  = 3'd6;
    localparam logic [2:0] REG_TS    = 3'd7;

    localparam int ST_OVF = 0;
    localparam int ST_UNF = 1;
    localparam int ST_OCC = 2;

    typedef enum logic {ARMED, WAIT_RDY} trk_e;

    // Increment v, sticking at the all-ones value of a w-bit counter (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// Per-channel timestamp FIFO: DEPTH entries of W bits held in registers.
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   clear              synchronous flush (wins over push/pop)
//   push, din          write request and data; dropped when full unless popping
//   pop, dout          read request and head entry (dout is the current head)
//   full, empty, count occupancy status
module ap_ctrl_ts_fifo
    import ap_perf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot the same cycle, so a full FIFO still takes a push.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wptr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// On-chip performance monitor for ap_ctrl_hs / ap_ctrl_chain handshakes.
// Per channel: transaction count, latency (last/min/max), start interval and
// downstream stall cycles; start timestamps of in-flight transactions are
// queued so pipelined (overlapping) transactions are paired in order.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   ap_start/ap_ready/ap_done/ap_continue   per-channel handshake taps
//   finish                       freeze statistics while high
//   clear                        synchronous zeroing of stats, FIFOs and flags
//   rd_en, rd_ch, rd_reg         read request
//   rd_valid, rd_data            registered read response (1 cycle)
module ap_ctrl_perf_monitor
    import ap_perf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int DEPTH  = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_CH-1:0]                      ap_start,
    input  logic [NUM_CH-1:0]                      ap_ready,
    input  logic [NUM_CH-1:0]                      ap_done,
    input  logic [NUM_CH-1:0]                      ap_continue,
    input  logic                                   finish,
    input  logic                                   clear,
    input  logic                                   rd_en,
    input  logic [(NUM_CH>1 ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    input  logic [2:0]                             rd_reg,
    output logic                                   rd_valid,
    output logic [CNT_W-1:0]                       rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0] ts;
    logic [NUM_CH-1:0][CNT_W-1:0] txn_a, last_a, min_a, max_a, ii_a, stall_a, stat_a;
    logic [CNT_W-1:0] rd_mux;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        trk_e             st_q, st_d;
        logic [CNT_W-1:0] hold_ts, acc_ts, head, lat, prev_ts;
        logic [CNT_W-1:0] txn, last_lat, min_lat, max_lat, last_ii, stall;
        logic             acc, done, bypass, lat_vld, has_prev, ovf, unf;
        logic             f_full, f_empty;
        logic [AW:0]      occ;
        logic [CNT_W-1:0] st_w;

        // Start tracker: an accept is start+ready, possibly ready arriving
        // later than start; the timestamp is that of the rising start.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                st_q    <= ARMED;
                hold_ts <= '0;
            end else begin
                st_q <= st_d;
                if (st_q == ARMED && ap_start[c] && !ap_ready[c]) hold_ts <= ts;
            end
        end

        always_comb begin
            st_d   = st_q;
            acc    = 1'b0;
            acc_ts = ts;
            case (st_q)
                ARMED: begin
                    if (ap_start[c]) begin
                        if (ap_ready[c]) acc  = 1'b1;
                        else             st_d = WAIT_RDY;
                    end
                end
                default: begin
                    if (ap_ready[c]) begin
                        acc    = 1'b1;
                        acc_ts = hold_ts;
                        st_d   = ARMED;
                    end else if (!ap_start[c]) begin
                        st_d = ARMED;
                    end
                end
            endcase
        end

        assign done    = ap_done[c] & ap_continue[c];
        // Accept and done in one cycle with nothing queued: the transaction
        // never touches the FIFO and its latency is measured directly.
        assign bypass  = acc & done & f_empty;
        assign lat_vld = done & (~f_empty | acc);
        assign lat     = ts - (bypass ? acc_ts : head);

        ap_ctrl_ts_fifo #(.DEPTH(DEPTH), .W(CNT_W)) u_fifo (
            .clock (clock),
            .reset (reset),
            .clear (clear),
            .push  (acc & ~bypass),
            .pop   (done),
            .din   (acc_ts),
            .dout  (head),
            .full  (f_full),
            .empty (f_empty),
            .count (occ)
        );

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                txn <= '0; last_lat <= '0; min_lat <= '1; max_lat <= '0;
                last_ii <= '0; stall <= '0; prev_ts <= '0; has_prev <= 1'b0;
                ovf <= 1'b0; unf <= 1'b0;
            end else if (clear) begin
                txn <= '0; last_lat <= '0; min_lat <= '1; max_lat <= '0;
                last_ii <= '0; stall <= '0; prev_ts <= '0; has_prev <= 1'b0;
                ovf <= 1'b0; unf <= 1'b0;
            end else if (!finish) begin
                if (acc) begin
                    txn      <= CNT_W'(sat_inc(64'(txn), CNT_W));
                    if (has_prev) last_ii <= acc_ts - prev_ts;
                    prev_ts  <= acc_ts;
                    has_prev <= 1'b1;
                    if (f_full && !done) ovf <= 1'b1;
                end
                if (lat_vld) begin
                    last_lat <= lat;
                    if (lat < min_lat) min_lat <= lat;
                    if (lat > max_lat) max_lat <= lat;
                end
                if (ap_done[c] && !ap_continue[c]) stall <= CNT_W'(sat_inc(64'(stall), CNT_W));
                if (done && f_empty && !acc) unf <= 1'b1;
            end
        end

        always_comb begin
            st_w = '0;
            st_w[ST_OVF] = ovf;
            st_w[ST_UNF] = unf;
            st_w[ST_OCC +: AW+1] = occ;
        end

        assign txn_a[c]   = txn;
        assign last_a[c]  = last_lat;
        assign min_a[c]   = min_lat;
        assign max_a[c]   = max_lat;
        assign ii_a[c]    = last_ii;
        assign stall_a[c] = stall;
        assign stat_a[c]  = st_w;
    end

    always_comb begin
        rd_mux = '0;
        if (int'(rd_ch) < NUM_CH) begin
            case (rd_reg)
                REG_TXN:   rd_mux = txn_a[rd_ch];
                REG_LAST:  rd_mux = last_a[rd_ch];
                REG_MIN:   rd_mux = min_a[rd_ch];
                REG_MAX:   rd_mux = max_a[rd_ch];
                REG_II:    rd_mux = ii_a[rd_ch];
                REG_STALL: rd_mux = stall_a[rd_ch];
                REG_STAT:  rd_mux = stat_a[rd_ch];
                REG_TS:    rd_mux = ts;
                default:   rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Bench for ap_ctrl_perf_monitor (4 channels, 8-bit counters, depth 4).
// A transaction-level reference model (queues of start times, integer stats)
// is advanced on every clock edge; each issued read pushes its expected value
// into a scoreboard that a separate monitor drains on rd_valid.
module tb_ap_ctrl_perf_monitor;
    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DEP  = 4;
    localparam int MASK = (1 << CW) - 1;

    logic clock = 1'b0, reset = 1'b1;
    logic [NCH-1:0] ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = '1;
    logic finish = 1'b0, clear = 1'b0, rd_en = 1'b0;
    logic [1:0] rd_ch = '0;
    logic [2:0] rd_reg = '0;
    logic rd_valid;
    logic [CW-1:0] rd_data;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW), .DEPTH(DEP)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_reg(rd_reg), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    int nchk = 0, nerr = 0;

    typedef struct { int ch; int rg; int ex; int cy; } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // ---------------- reference model ----------------
    int ts_m = 0, cyc_n = 0;
    int q[NCH][$];
    bit wait_m[NCH];
    int wait_ts_m[NCH];
    int txn_m[NCH], last_m[NCH], min_m[NCH], max_m[NCH], ii_m[NCH], stall_m[NCH], prev_m[NCH];
    bit hasp_m[NCH], ovf_m[NCH], unf_m[NCH];

    function automatic int sinc(int v);
        return (v >= MASK) ? v : v + 1;
    endfunction

    task automatic clr_stats(input int c);
        txn_m[c] = 0; last_m[c] = 0; min_m[c] = MASK; max_m[c] = 0;
        ii_m[c] = 0; stall_m[c] = 0; prev_m[c] = 0; hasp_m[c] = 0;
        ovf_m[c] = 0; unf_m[c] = 0;
    endtask

    function automatic int model_reg(int ch, int rg);
        case (rg)
            0: return txn_m[ch];
            1: return last_m[ch];
            2: return min_m[ch];
            3: return max_m[ch];
            4: return ii_m[ch];
            5: return stall_m[ch];
            6: return (ovf_m[ch] ? 1 : 0) | (unf_m[ch] ? 2 : 0) | (q[ch].size() << 2);
            default: return ts_m;
        endcase
    endfunction

    task automatic step(input int c);
        bit acc, byp, got, dn;
        int t, lat;
        acc = 0; byp = 0; got = 0; lat = 0; t = ts_m;
        if (wait_m[c]) begin
            if (ap_ready[c]) begin acc = 1; t = wait_ts_m[c]; wait_m[c] = 0; end
            else if (!ap_start[c]) wait_m[c] = 0;
        end else if (ap_start[c]) begin
            if (ap_ready[c]) acc = 1;
            else begin wait_m[c] = 1; wait_ts_m[c] = ts_m; end
        end
        dn = ap_done[c] && ap_continue[c];
        if (clear) begin q[c].delete(); clr_stats(c); return; end
        if (dn) begin
            if (q[c].size() > 0) begin lat = (ts_m - q[c].pop_front()) & MASK; got = 1; end
            else if (acc) begin lat = (ts_m - t) & MASK; got = 1; byp = 1; end
            else if (!finish) unf_m[c] = 1;
        end
        if (acc && !byp) begin
            if (q[c].size() < DEP) q[c].push_back(t);
            else if (!finish) ovf_m[c] = 1;
        end
        if (finish) return;
        if (acc) begin
            txn_m[c] = sinc(txn_m[c]);
            if (hasp_m[c]) ii_m[c] = (t - prev_m[c]) & MASK;
            prev_m[c] = t; hasp_m[c] = 1;
        end
        if (got) begin
            last_m[c] = lat;
            if (lat < min_m[c]) min_m[c] = lat;
            if (lat > max_m[c]) max_m[c] = lat;
        end
        if (ap_done[c] && !ap_continue[c]) stall_m[c] = sinc(stall_m[c]);
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            ts_m = 0; sbq.delete();
            for (int c = 0; c < NCH; c++) begin q[c].delete(); wait_m[c] = 0; clr_stats(c); end
        end else begin
            if (rd_en) sbq.push_back('{int'(rd_ch), int'(rd_reg), model_reg(int'(rd_ch), int'(rd_reg)), cyc_n});
            for (int c = 0; c < NCH; c++) step(c);
            ts_m = (ts_m + 1) & MASK;
            cyc_n++;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (rd_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL sb unexpected rd_valid: got data %0d expected no response", rd_data);
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("rd ch%0d reg%0d data", mon_e.ch, mon_e.rg), int'(rd_data), mon_e.ex);
                chk($sformatf("rd ch%0d reg%0d latency", mon_e.ch, mon_e.rg), cyc_n, mon_e.cy + 1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_ts(input int v);
        for (int i = 0; i < 300 && ts_m != v; i++) cyc();
        if (ts_m != v) chk("wait_ts bound", ts_m, v);
    endtask

    task automatic rd_direct(input int ch, input int rg, input int exp, input string nm);
        rd_en = 1; rd_ch = 2'(ch); rd_reg = 3'(rg);
        cyc();
        rd_en = 0;
        @(negedge clock);
        chk(nm, rd_valid ? int'(rd_data) : -1, exp);
        @(posedge clock); #1;
    endtask

    task automatic dump(input int ch);
        for (int rg = 0; rg < 8; rg++) begin
            rd_en = 1; rd_ch = 2'(ch); rd_reg = 3'(rg);
            cyc();
        end
        rd_en = 0;
        cyc(2);
    endtask

    task automatic pulse_acc(input int ch);
        ap_start[ch] = 1; ap_ready[ch] = 1; cyc(); ap_start[ch] = 0; ap_ready[ch] = 0;
    endtask

    task automatic pulse_done(input int ch);
        ap_done[ch] = 1; cyc(); ap_done[ch] = 0;
    endtask

    initial begin
        // reset values
        cyc(3);
        @(negedge clock);
        chk("reset rd_valid", int'(rd_valid), 0);
        chk("reset rd_data", int'(rd_data), 0);
        @(posedge clock); #1;
        reset = 0;
        rd_direct(0, 2, MASK, "reset min_lat");

        // single transaction on ch0: start@10, ready@12, done@20
        wait_ts(10);
        ap_start[0] = 1; cyc(2);
        ap_ready[0] = 1; cyc();
        ap_start[0] = 0; ap_ready[0] = 0;
        wait_ts(20);
        pulse_done(0);
        rd_direct(0, 0, 1, "single txn_count");
        rd_direct(0, 1, 10, "single last_lat");
        rd_direct(0, 2, 10, "single min_lat");
        rd_direct(0, 3, 10, "single max_lat");

        // pipelined on ch1: accepts at 40,42,44; dones at 47,49,51
        wait_ts(40);
        pulse_acc(1); cyc(); pulse_acc(1); cyc(); pulse_acc(1);
        rd_direct(1, 6, 3 << 2, "pipe occupancy peak");
        wait_ts(47); pulse_done(1);
        wait_ts(49); pulse_done(1);
        wait_ts(51); pulse_done(1);
        rd_direct(1, 1, 7, "pipe last_lat");
        rd_direct(1, 3, 7, "pipe max_lat");
        rd_direct(1, 4, 2, "pipe last_ii");
        rd_direct(1, 0, 3, "pipe txn_count");

        // overflow on ch2
        ap_start[2] = 1; ap_ready[2] = 1; cyc(5); ap_start[2] = 0; ap_ready[2] = 0;
        rd_direct(2, 6, 1 | (4 << 2), "ovf status full");
        rd_direct(2, 0, 5, "ovf txn_count");
        ap_done[2] = 1; cyc(4); ap_done[2] = 0;
        rd_direct(2, 6, 1, "ovf status drained");

        // back-pressure then bypass on ch3
        ap_done[3] = 1; ap_continue[3] = 0; cyc(6); ap_done[3] = 0; ap_continue[3] = 1;
        rd_direct(3, 5, 6, "stall_cycles");
        ap_start[3] = 1; ap_ready[3] = 1; ap_done[3] = 1; cyc();
        ap_start[3] = 0; ap_ready[3] = 0; ap_done[3] = 0;
        rd_direct(3, 1, 0, "bypass last_lat");
        rd_direct(3, 6, 0, "bypass status");

        // timestamp wrap on ch0: accept@253, done@4
        wait_ts(253); pulse_acc(0);
        wait_ts(4); pulse_done(0);
        rd_direct(0, 1, 7, "wrap last_lat");
        rd_direct(0, 2, 7, "wrap min_lat");
        rd_direct(0, 3, 10, "wrap max_lat");

        // finish freezes ch1 stats while the FIFO keeps moving
        finish = 1;
        pulse_acc(1); cyc(2); pulse_done(1);
        finish = 0;
        rd_direct(1, 0, 3, "finish txn_count");
        rd_direct(1, 1, 7, "finish last_lat");
        rd_direct(1, 6, 0, "finish status");

        // clear with a simultaneous done on ch2
        clear = 1; ap_done[2] = 1; cyc(); clear = 0; ap_done[2] = 0;
        rd_direct(2, 0, 0, "clear txn_count");
        rd_direct(2, 2, MASK, "clear min_lat");
        rd_direct(2, 6, 0, "clear status");

        // reset mid-transaction
        pulse_acc(0);
        ap_start[1] = 1; cyc();
        reset = 1; cyc(2);
        @(negedge clock);
        chk("midreset rd_valid", int'(rd_valid), 0);
        chk("midreset rd_data", int'(rd_data), 0);
        @(posedge clock); #1;
        ap_start[1] = 0; reset = 0;
        rd_direct(0, 6, 0, "midreset status");
        rd_direct(0, 2, MASK, "midreset min_lat");
        for (int c = 0; c < NCH; c++) dump(c);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                ap_start[c]    = ($urandom_range(0, 99) < 40);
                ap_ready[c]    = ($urandom_range(0, 99) < 50);
                ap_done[c]     = ($urandom_range(0, 99) < 35);
                ap_continue[c] = ($urandom_range(0, 99) < 75);
            end
            finish = ($urandom_range(0, 99) < 3);
            clear  = ($urandom_range(0, 299) == 0);
            rd_en  = 1'($urandom_range(0, 1));
            rd_ch  = 2'($urandom_range(0, NCH - 1));
            rd_reg = 3'($urandom_range(0, 7));
            cyc();
        end
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
        finish = 0; clear = 0; rd_en = 0;
        cyc(2);
        for (int c = 0; c < NCH; c++) dump(c);
        cyc(3);
        chk("scoreboard drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
